// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (instruction fetch / load-store) arbiter in front of a
//            single-port, one-cycle-latency memory, with IF starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [3:0]        ls_be,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int                 c_CNT_W      = $clog2(STARVE_MAX) + 1;
    localparam logic [c_CNT_W-1:0] c_STARVE_LIM = c_CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_LS   = 2'd2
    } rsp_sel_t;

    rsp_sel_t           r_rsp_sel;
    rsp_sel_t           w_rsp_sel_nxt;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [c_CNT_W-1:0] w_starve_cnt_nxt;
    logic               w_starve_hit;
    logic               w_if_gnt;
    logic               w_ls_gnt;

    // Grants are masked by rst so nothing reaches the memory during reset.
    always_comb begin
        w_starve_hit = (r_starve_cnt == c_STARVE_LIM);
        w_if_gnt     = 1'b0;
        w_ls_gnt     = 1'b0;
        if (!rst) begin
            w_if_gnt = if_req && (!ls_req || w_starve_hit);
            w_ls_gnt = ls_req && !(if_req && w_starve_hit);
        end
    end

    always_comb begin
        w_starve_cnt_nxt = '0;
        if (if_req && !w_if_gnt) begin
            w_starve_cnt_nxt = w_starve_hit ? r_starve_cnt : r_starve_cnt + 1'b1;
        end
    end

    // Stores complete at grant, so only reads claim the response slot.
    always_comb begin
        w_rsp_sel_nxt = RSP_NONE;
        if (w_if_gnt) begin
            w_rsp_sel_nxt = RSP_IF;
        end else if (w_ls_gnt && !ls_we) begin
            w_rsp_sel_nxt = RSP_LS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_rsp_sel    <= RSP_NONE;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_rsp_sel    <= w_rsp_sel_nxt;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (w_if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (w_ls_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
    end

    always_comb begin
        if_gnt    = w_if_gnt;
        ls_gnt    = w_ls_gnt;
        if_rvalid = (r_rsp_sel == RSP_IF);
        ls_rvalid = (r_rsp_sel == RSP_LS);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        ls_rdata  = ls_rvalid ? mem_rdata : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed plus randomized checks of mem_arbiter against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_AW = 32;
    localparam int c_SM = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req, ls_req, ls_we;
    logic [c_AW-1:0] if_addr, ls_addr, mem_addr;
    logic [3:0]      ls_be, mem_be;
    logic [31:0]     ls_wdata, mem_rdata, mem_wdata, if_rdata, ls_rdata;
    logic            if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;   // consecutive IF denials
    int m_pend   = 0;   // 0 none, 1 IF read outstanding, 2 LS read outstanding

    mem_arbiter #(.ADDR_W(c_AW), .STARVE_MAX(c_SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_be(ls_be),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr,
                         input logic lreq, input logic lwe, input logic [31:0] laddr,
                         input logic [3:0] lbe, input logic [31:0] lwd, input logic [31:0] rd);
        if_req = ireq; if_addr = iaddr;
        ls_req = lreq; ls_we = lwe; ls_addr = laddr; ls_be = lbe; ls_wdata = lwd;
        mem_rdata = rd;
    endtask

    // Entered just after a rising edge; compares one cycle, then advances the model.
    task automatic run_cycle();
        logic e_if, e_ls;
        #3;
        e_if = if_req && (!ls_req || m_cnt == c_SM);
        e_ls = ls_req && !e_if;
        check_eq("if_gnt", if_gnt, e_if);
        check_eq("ls_gnt", ls_gnt, e_ls);
        check_eq("mem_en", mem_en, e_if || e_ls);
        if (e_if) begin
            check_eq("if_mem_we", mem_we, 0);
            check_eq("if_mem_be", mem_be, 4'hF);
            check_eq("if_mem_addr", mem_addr, if_addr);
        end else if (e_ls) begin
            check_eq("ls_mem_we", mem_we, ls_we);
            check_eq("ls_mem_be", mem_be, ls_be);
            check_eq("ls_mem_addr", mem_addr, ls_addr);
            check_eq("ls_mem_wdata", mem_wdata, ls_wdata);
        end else begin
            check_eq("idle_mem", {mem_we, mem_be, mem_addr, mem_wdata}, 0);
        end
        check_eq("if_rvalid", if_rvalid, m_pend == 1);
        check_eq("if_rdata", if_rdata, (m_pend == 1) ? mem_rdata : 32'h0);
        check_eq("ls_rvalid", ls_rvalid, m_pend == 2);
        check_eq("ls_rdata", ls_rdata, (m_pend == 2) ? mem_rdata : 32'h0);
        @(posedge clk);
        m_cnt  = (if_req && !e_if) ? ((m_cnt < c_SM) ? m_cnt + 1 : c_SM) : 0;
        m_pend = e_if ? 1 : ((e_ls && !ls_we) ? 2 : 0);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        // Requests during reset must be ignored entirely.
        drive(1, 32'h44, 1, 0, 32'h88, 4'hF, 32'h1234, 32'hFFFF_FFFF);
        #1;
        check_eq("rst_outputs", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, mem_be},
                 0);
        check_eq("rst_data", {if_rdata, ls_rdata}, 0);
        check_eq("rst_addr", mem_addr, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Single fetch and its response.
        drive(1, 32'h10, 0, 0, 0, 0, 0, 32'hABAB_ABAB);
        run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0050_0093);
        #2;
        check_eq("fetch_rdata", {if_rvalid, if_rdata, ls_rvalid}, {1'b1, 32'h0050_0093, 1'b0});
        run_cycle();

        // Partial store: no response afterwards.
        drive(0, 0, 1, 1, 32'h200, 4'b0011, 32'hDEAD_BEEF, 0);
        #2;
        check_eq("store_cmd", {ls_gnt, mem_we, mem_be, mem_wdata}, {1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF});
        run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h5555_5555);
        #2;
        check_eq("store_no_rvalid", {if_rvalid, ls_rvalid}, 0);
        run_cycle();

        // Contention: LS wins until IF has been denied STARVE_MAX times.
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h100 + i * 4, 1, 0, 32'h300 + i * 4, 4'hF, 0, $urandom);
            #2;
            check_eq("starve_pat", {if_gnt, ls_gnt}, (i == 4) ? 2'b10 : 2'b01);
            if (i == 5) check_eq("starve_clr", dut.r_starve_cnt, 0);
            run_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, $urandom);
        run_cycle();

        // Back-to-back IF read then LS read.
        drive(1, 32'h20, 0, 0, 0, 0, 0, $urandom);
        run_cycle();
        drive(0, 0, 1, 0, 32'h400, 4'hF, 0, 32'h11);
        #2;
        check_eq("b2b_if", {if_rvalid, if_rdata, ls_rvalid}, {1'b1, 32'h11, 1'b0});
        run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h22);
        #2;
        check_eq("b2b_ls", {ls_rvalid, ls_rdata, if_rvalid}, {1'b1, 32'h22, 1'b0});
        run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h33);
        run_cycle();

        // Reset right after a fetch grant drops the outstanding read.
        drive(1, 32'h40, 0, 0, 0, 0, 0, $urandom);
        run_cycle();
        mem_rdata = 32'hCAFE_0001;
        rst = 1'b1;
        #1;
        check_eq("arst_rvalid", {if_rvalid, if_rdata}, 0);
        check_eq("arst_gnt", {if_gnt, ls_gnt, mem_en, mem_addr}, 0);
        m_cnt  = 0;
        m_pend = 0;
        @(posedge clk); #1;
        check_eq("arst_hold", {if_rvalid, if_gnt, mem_en}, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_resume", if_gnt, 1);
        run_cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, $urandom, ($urandom % 4) != 0, $urandom % 2,
                  $urandom, 4'($urandom), $urandom, $urandom);
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
